alu_sequencer: RTL and testbench

Single-issue control sequencer that drives the uBio ALU. It accepts 32-bit instruction words over a valid/ready handshake and decodes them. It reads a 16x16 register file, presents opcode and operands to the ALU, and captures result, result2 and the C/V/Z/N flags. It then writes the results back to the register file. It is the issuing side of the ALU's alu_ctl/opa/opb/iv16 interface.

---
 rtl/alu_sequencer.sv | 169 ++++++++++++++++
 tb/tb_alu_sequencer.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_sequencer.sv
// Single-issue sequencer: decodes 32-bit instructions, drives the uBio ALU and writes results back to a 16x16 register file.
// Each accepted instruction takes 3 cycles (4 for MUL), and instr_ready is high only while IDLE.
module alu_sequencer #(
  parameter int NREGS = 16,
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             instr_valid,
  input  logic [31:0]      instr,
  output logic             instr_ready,
  output logic [7:0]       alu_ctl,
  output logic [WIDTH-1:0] opa,
  output logic [WIDTH-1:0] opb,
  output logic [WIDTH-1:0] iv16,
  input  logic [WIDTH-1:0] alu_result,
  input  logic [WIDTH-1:0] alu_result2,
  input  logic             alu_c,
  input  logic             alu_v,
  input  logic             alu_z,
  input  logic             alu_n,
  output logic [3:0]       flags,
  output logic             done,
  output logic             illegal,
  input  logic [3:0]       dbg_addr,
  output logic [WIDTH-1:0] dbg_data
);

  localparam logic [7:0] OP_NOP  = 8'h00;
  localparam logic [7:0] OP_ORI  = 8'h0A;
  localparam logic [7:0] OP_ANDI = 8'h0C;
  localparam logic [7:0] OP_ADD  = 8'h12;
  localparam logic [7:0] OP_SUB  = 8'h13;
  localparam logic [7:0] OP_MUL  = 8'h14;
  localparam logic [7:0] OP_ADDI = 8'h15;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_WB, S_WB_HI} state_t;

  state_t           state_q, state_d;
  logic [7:0]       op_q, op_d;
  logic [3:0]       rd_q, rd_d;
  logic [7:0]       alu_ctl_q, alu_ctl_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] iv16_q, iv16_d;
  logic [WIDTH-1:0] res_lo_q, res_lo_d;
  logic [WIDTH-1:0] res_hi_q, res_hi_d;
  logic [3:0]       flags_q, flags_d;
  logic [WIDTH-1:0] regs_q [NREGS];
  logic             we_lo, we_hi;
  logic [3:0]       rd_hi;

  logic [7:0] in_op;
  logic [3:0] in_rd, in_rs, in_rt;
  assign in_op = instr[31:24];
  assign in_rd = instr[23:20];
  assign in_rs = instr[19:16];
  assign in_rt = instr[15:12];
  assign rd_hi = rd_q + 4'd1;

  function automatic logic is_rtype(input logic [7:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_MUL);
  endfunction

  function automatic logic is_itype(input logic [7:0] op);
    return (op == OP_ORI) || (op == OP_ANDI) || (op == OP_ADDI);
  endfunction

  // r0 is never written, but the read is forced to zero regardless
  function automatic logic [WIDTH-1:0] rf_read(input logic [3:0] a);
    return (a == 4'd0) ? '0 : regs_q[a];
  endfunction

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    rd_d        = rd_q;
    alu_ctl_d   = 8'h00;
    opa_d       = '0;
    opb_d       = '0;
    iv16_d      = '0;
    res_lo_d    = res_lo_q;
    res_hi_d    = res_hi_q;
    flags_d     = flags_q;
    we_lo       = 1'b0;
    we_hi       = 1'b0;
    instr_ready = 1'b0;
    done        = 1'b0;
    illegal     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) begin
          op_d    = in_op;
          rd_d    = in_rd;
          state_d = S_EXEC;
          if (is_rtype(in_op)) begin
            alu_ctl_d = in_op;
            opa_d     = rf_read(in_rs);
            opb_d     = rf_read(in_rt);
          end else if (is_itype(in_op)) begin
            alu_ctl_d = in_op;
            opb_d     = rf_read(in_rs);
            iv16_d    = instr[15:0];
          end
        end
      end
      S_EXEC: begin
        res_lo_d = alu_result;
        res_hi_d = alu_result2;
        if (is_rtype(op_q) || is_itype(op_q))
          flags_d = {alu_c, alu_v, alu_z, alu_n};
        state_d = S_WB;
      end
      S_WB: begin
        we_lo = is_rtype(op_q) || is_itype(op_q);
        if (op_q == OP_MUL) begin
          state_d = S_WB_HI;
        end else begin
          done    = 1'b1;
          illegal = !(is_rtype(op_q) || is_itype(op_q) || (op_q == OP_NOP));
          state_d = S_IDLE;
        end
      end
      S_WB_HI: begin
        we_hi   = 1'b1;
        done    = 1'b1;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      op_q      <= 8'h00;
      rd_q      <= 4'd0;
      alu_ctl_q <= 8'h00;
      opa_q     <= '0;
      opb_q     <= '0;
      iv16_q    <= '0;
      res_lo_q  <= '0;
      res_hi_q  <= '0;
      flags_q   <= 4'h0;
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      rd_q      <= rd_d;
      alu_ctl_q <= alu_ctl_d;
      opa_q     <= opa_d;
      opb_q     <= opb_d;
      iv16_q    <= iv16_d;
      res_lo_q  <= res_lo_d;
      res_hi_q  <= res_hi_d;
      flags_q   <= flags_d;
      if (we_lo && (rd_q != 4'd0)) regs_q[rd_q] <= res_lo_q;
      if (we_hi && (rd_hi != 4'd0)) regs_q[rd_hi] <= res_hi_q;
    end
  end

  assign alu_ctl  = alu_ctl_q;
  assign opa      = opa_q;
  assign opb      = opb_q;
  assign iv16     = iv16_q;
  assign flags    = flags_q;
  assign dbg_data = rf_read(dbg_addr);

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: ALU stub, architectural reference model and done-driven scoreboard.
module tb_alu_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_valid;
  logic [31:0] instr;
  logic        instr_ready;
  logic [7:0]  alu_ctl;
  logic [15:0] opa, opb, iv16;
  logic [15:0] alu_result, alu_result2;
  logic        alu_c, alu_v, alu_z, alu_n;
  logic [3:0]  flags;
  logic        done, illegal;
  logic [3:0]  dbg_addr;
  logic [15:0] dbg_data;

  alu_sequencer #(.NREGS(16), .WIDTH(16)) dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr(instr),
    .instr_ready(instr_ready), .alu_ctl(alu_ctl), .opa(opa), .opb(opb), .iv16(iv16),
    .alu_result(alu_result), .alu_result2(alu_result2),
    .alu_c(alu_c), .alu_v(alu_v), .alu_z(alu_z), .alu_n(alu_n),
    .flags(flags), .done(done), .illegal(illegal),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_pass = 0;

  typedef struct {
    logic [3:0] flags;
    logic       ill;
    int         due;
  } exp_t;
  exp_t sb[$];

  logic [15:0] m_reg [16];
  logic [3:0]  m_flags;

  // ALU behaviour: returns {result2, result, C, V, Z, N}
  function automatic logic [35:0] alu_fn(input logic [7:0] c, input logic [15:0] a,
                                         input logic [15:0] b, input logic [15:0] imm);
    logic [16:0] s;
    logic [31:0] p;
    logic [15:0] lo, hi;
    logic        cf, vf;
    lo = 16'h0; hi = 16'h0; cf = 1'b0; vf = 1'b0;
    case (c)
      8'h12: begin
        s = {1'b0, a} + {1'b0, b}; lo = s[15:0]; cf = s[16];
        vf = (a[15] == b[15]) && (lo[15] != a[15]);
      end
      8'h15: begin
        s = {1'b0, b} + {1'b0, imm}; lo = s[15:0]; cf = s[16];
        vf = (b[15] == imm[15]) && (lo[15] != b[15]);
      end
      8'h13: begin
        s = {1'b0, a} - {1'b0, b}; lo = s[15:0]; cf = s[16];
        vf = (a[15] != b[15]) && (lo[15] != a[15]);
      end
      8'h14: begin
        p = a * b; lo = p[15:0]; hi = p[31:16]; cf = (hi != 16'h0);
      end
      8'h0A: return {16'h0, b | imm, 4'h0};
      8'h0C: return {16'h0, b & imm, 4'h0};
      default: return 36'h0;
    endcase
    return {hi, lo, cf, vf, (lo == 16'h0), lo[15]};
  endfunction

  assign {alu_result2, alu_result, alu_c, alu_v, alu_z, alu_n} = alu_fn(alu_ctl, opa, opb, iv16);

  task automatic check(input string name, input logic [35:0] act, input logic [35:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [31:0] ri(input logic [7:0] op, input logic [3:0] rd,
                                     input logic [3:0] rs, input logic [3:0] rt);
    return {op, rd, rs, rt, 12'h000};
  endfunction

  function automatic logic [31:0] ii(input logic [7:0] op, input logic [3:0] rd,
                                     input logic [3:0] rs, input logic [15:0] imm);
    return {op, rd, rs, imm};
  endfunction

  task automatic sweep();
    for (int i = 0; i < 16; i++) begin
      dbg_addr = 4'(i);
      #1;
      check($sformatf("dbg_r%0d", i), dbg_data, m_reg[i]);
    end
  endtask

  task automatic dbg_chk(input string name, input logic [3:0] a, input logic [15:0] exp);
    dbg_addr = a;
    #1;
    check(name, dbg_data, exp);
  endtask

  task automatic issue(input logic [31:0] w, input bit do_rst);
    logic [7:0]  op, ectl;
    logic [3:0]  rd, rs, rt, rh;
    logic [15:0] imm, a, b, iv;
    logic [35:0] r;
    exp_t        e;
    int          t;
    op = w[31:24]; rd = w[23:20]; rs = w[19:16]; rt = w[15:12]; imm = w[15:0];
    ectl = 8'h00; a = 16'h0; b = 16'h0; iv = 16'h0;
    if (op inside {8'h12, 8'h13, 8'h14}) begin
      ectl = op; a = m_reg[rs]; b = m_reg[rt];
    end else if (op inside {8'h0A, 8'h0C, 8'h15}) begin
      ectl = op; b = m_reg[rs]; iv = imm;
    end
    @(negedge clk);
    t = 0;
    while (instr_ready !== 1'b1 && t < 20) begin @(negedge clk); t++; end
    if (instr_ready !== 1'b1) begin
      check("ready_timeout", instr_ready, 1);
      return;
    end
    instr = w;
    instr_valid = 1'b1;
    if (!do_rst) begin
      r = alu_fn(ectl, a, b, iv);
      if (ectl != 8'h00) begin
        m_flags = r[3:0];
        if (rd != 4'd0) m_reg[rd] = r[19:4];
        rh = rd + 4'd1;
        if (op == 8'h14 && rh != 4'd0) m_reg[rh] = r[35:20];
      end
      e.flags = m_flags;
      e.ill   = (ectl == 8'h00) && (op != 8'h00);
      e.due   = cyc + ((op == 8'h14) ? 3 : 2);
      sb.push_back(e);
    end
    @(negedge clk);
    check("exec_alu_ctl", alu_ctl, ectl);
    check("exec_opa", opa, a);
    check("exec_opb", opb, b);
    check("exec_iv16", iv16, iv);
    check("busy_ready", instr_ready, 0);
    instr = $urandom;
    if (do_rst) begin
      rst = 1'b1;
      #1;
      check("rst_ready", instr_ready, 1);
      check("rst_done", done, 0);
      check("rst_flags", flags, 0);
      check("rst_alu_ctl", alu_ctl, 0);
      for (int i = 0; i < 16; i++) m_reg[i] = 16'h0;
      m_flags = 4'h0;
      instr_valid = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      sweep();
      return;
    end
    @(negedge clk);
    check("wb_alu_ctl", alu_ctl, 0);
    check("wb_operands", {opa, opb, iv16}, 0);
    instr_valid = 1'b0;
    t = 0;
    while (instr_ready !== 1'b1 && t < 10) begin @(negedge clk); t++; end
    if (instr_ready !== 1'b1) check("retire_timeout", instr_ready, 1);
    sweep();
  endtask

  // Scoreboard monitor: every retirement is matched against the oldest expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (done === 1'b1) begin
        if (sb.size() == 0) begin
          check("unexpected_done", done, 0);
        end else begin
          e = sb.pop_front();
          check("done_cycle", cyc, e.due);
          check("illegal", illegal, e.ill);
          check("flags", flags, e.flags);
        end
      end else if (illegal !== 1'b0) begin
        check("illegal_without_done", illegal, 0);
      end
    end
  end

  initial begin
    logic [7:0]  op;
    logic [31:0] w;
    int          sel;
    rst = 1'b1; instr_valid = 1'b0; instr = 32'h0; dbg_addr = 4'd0;
    for (int i = 0; i < 16; i++) m_reg[i] = 16'h0;
    m_flags = 4'h0;
    repeat (2) @(negedge clk);
    check("reset_ready", instr_ready, 1);
    check("reset_alu", {alu_ctl, opa, opb}, 0);
    check("reset_iv16", iv16, 0);
    check("reset_flags", flags, 0);
    check("reset_done", {done, illegal}, 0);
    rst = 1'b0;
    sweep();

    issue(ii(8'h15, 1, 0, 16'h0005), 0);
    issue(ii(8'h15, 2, 0, 16'h000A), 0);
    issue(ri(8'h12, 3, 1, 2), 0);
    dbg_chk("t1_r3", 3, 16'h000F);
    check("t1_zn", flags[1:0], 2'b00);
    issue(ri(8'h13, 4, 1, 2), 0);
    dbg_chk("t2_r4", 4, 16'hFFFB);
    check("t2_zn", flags[1:0], 2'b01);
    issue(ri(8'h13, 5, 1, 1), 0);
    dbg_chk("t2_r5", 5, 16'h0000);
    check("t2_z", flags[1], 1'b1);
    issue(ii(8'h15, 1, 0, 16'h1234), 0);
    issue(ii(8'h15, 2, 0, 16'h0100), 0);
    issue(ri(8'h14, 6, 1, 2), 0);
    dbg_chk("t3_r6", 6, 16'h3400);
    dbg_chk("t3_r7", 7, 16'h0012);
    issue(ri(8'h14, 15, 1, 2), 0);
    dbg_chk("t3_r15", 15, 16'h3400);
    dbg_chk("t3_r0", 0, 16'h0000);
    issue(ii(8'h15, 1, 0, 16'h00F0), 0);
    issue(ii(8'h0A, 2, 1, 16'h0F0F), 0);
    dbg_chk("t4_r2", 2, 16'h0FFF);
    issue(ii(8'h0C, 3, 1, 16'h0FF0), 0);
    dbg_chk("t4_r3", 3, 16'h00F0);
    check("t4_flags", flags, 0);
    issue(ii(8'hFF, 3, 1, 16'h1234), 0);
    dbg_chk("t5_r3", 3, 16'h00F0);
    issue(32'h0000_0000, 0);
    issue(ri(8'h12, 3, 1, 2), 1);

    for (int k = 0; k < 60; k++) begin
      sel = $urandom_range(0, 7);
      case (sel)
        0: op = 8'h12;
        1: op = 8'h13;
        2: op = 8'h14;
        3: op = 8'h0A;
        4: op = 8'h0C;
        5: op = 8'h15;
        6: op = 8'h00;
        default: op = 8'($urandom);
      endcase
      w = {op, 24'($urandom)};
      issue(w, k == 40);
    end

    repeat (5) @(negedge clk);
    check("scoreboard_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
